icw_init_sequencer: RTL and testbench

//  Consumes the bus control logic's write strobes and internal_data_bus. Runs the 8259A ICW1..ICW4 init sequence.

---
 rtl/pic8259_pkg.sv | 23 ++
 rtl/icw_init_sequencer.sv | 136 +++++++++++++
 tb/tb_icw_init_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pic8259_pkg.sv
// Shared 8259A init-sequencer types: ICW FSM state encoding and ICW bit positions.
package pic8259_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } icw_state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_ADI  = 2;
    localparam int ICW1_LTIM = 3;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

endpackage

// File: rtl/icw_init_sequencer.sv
// 8259A ICW1..ICW4 init sequencer plus OCW1 mask register; holds decoded mode/config fields.
// Optional protocol checker driving seq_error is enabled by defining ICW_SEQ_ERROR_EN.
module icw_init_sequencer
    import pic8259_pkg::*;
#(
    parameter logic [7:0] IMR_RESET_VALUE = 8'hFF,
    parameter logic [7:0] IMR_INIT_VALUE  = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       init_pulse,
    output logic       init_done,
    output logic       ltim,
    output logic       adi,
    output logic       single_mode,
    output logic [2:0] icw1_addr,
    output logic [7:0] vector_address,
    output logic [7:0] cascade_config,
    output logic       sfnm,
    output logic       buf_mode,
    output logic       master_slave,
    output logic       aeoi,
    output logic       upm,
    output logic [7:0] imr,
    output logic       seq_error
);

    icw_state_t state, state_n;
    logic       ic4;
    logic       wr_a0;
    logic       icw1;

    assign icw1  = write_initial_command_word_1;
    assign wr_a0 = write_initial_command_word_2_4 | write_operation_control_word_1;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (icw1) begin
            state_n = WAIT_ICW2;
        end else if (wr_a0) begin
            case (state)
                WAIT_ICW2: begin
                    if (!single_mode) state_n = WAIT_ICW3;
                    else if (ic4)     state_n = WAIT_ICW4;
                    else              state_n = READY;
                end
                WAIT_ICW3: state_n = ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: state_n = READY;
                default:   state_n = state;
            endcase
        end
    end

    // Field registers: ICW1 always wins over a coincident A0 write.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_pulse     <= 1'b0;
            init_done      <= 1'b0;
            ltim           <= 1'b0;
            adi            <= 1'b0;
            single_mode    <= 1'b0;
            ic4            <= 1'b0;
            icw1_addr      <= 3'd0;
            vector_address <= 8'h00;
            cascade_config <= 8'h00;
            sfnm           <= 1'b0;
            buf_mode       <= 1'b0;
            master_slave   <= 1'b0;
            aeoi           <= 1'b0;
            upm            <= 1'b0;
            imr            <= IMR_RESET_VALUE;
        end else begin
            init_pulse <= icw1;
            init_done  <= (state_n == READY);
            if (icw1) begin
                icw1_addr      <= internal_data_bus[7:5];
                ltim           <= internal_data_bus[ICW1_LTIM];
                adi            <= internal_data_bus[ICW1_ADI];
                single_mode    <= internal_data_bus[ICW1_SNGL];
                ic4            <= internal_data_bus[ICW1_IC4];
                cascade_config <= 8'h00;
                sfnm           <= 1'b0;
                buf_mode       <= 1'b0;
                master_slave   <= 1'b0;
                aeoi           <= 1'b0;
                upm            <= 1'b0;
                imr            <= IMR_INIT_VALUE;
            end else if (wr_a0) begin
                case (state)
                    WAIT_ICW2: vector_address <= internal_data_bus;
                    WAIT_ICW3: cascade_config <= internal_data_bus;
                    WAIT_ICW4: begin
                        sfnm         <= internal_data_bus[ICW4_SFNM];
                        buf_mode     <= internal_data_bus[ICW4_BUF];
                        master_slave <= internal_data_bus[ICW4_MS];
                        aeoi         <= internal_data_bus[ICW4_AEOI];
                        upm          <= internal_data_bus[ICW4_UPM];
                    end
                    READY:   imr <= internal_data_bus;
                    default: ;
                endcase
            end
        end
    end

`ifdef ICW_SEQ_ERROR_EN
    logic seq_error_q;

    // Sticky until reset or a fresh ICW1 restarts the protocol.
    always_ff @(posedge clock) begin
        if (reset || icw1)
            seq_error_q <= 1'b0;
        else if ((wr_a0 && state == IDLE) ||
                 ((write_operation_control_word_2 || write_operation_control_word_3) && state != READY))
            seq_error_q <= 1'b1;
    end

    assign seq_error = seq_error_q;
`else
    logic unused_ocw;
    assign unused_ocw = write_operation_control_word_2 | write_operation_control_word_3;
    assign seq_error  = 1'b0;
`endif

endmodule

// File: tb/tb_icw_init_sequencer.sv
// Directed bench for icw_init_sequencer: ICW sequences, OCW1 alias, re-init, reset, ICW1/A0 collision.
module tb_icw_init_sequencer;
    import pic8259_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       init_pulse, init_done, ltim, adi, single_mode;
    logic [2:0] icw1_addr;
    logic [7:0] vector_address, cascade_config, imr;
    logic       sfnm, buf_mode, master_slave, aeoi, upm, seq_error;

    int total_checks  = 0;
    int passed_checks = 0;

    icw_init_sequencer dut (
        .clock                          (clock),
        .reset                          (reset),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (write_initial_command_word_1),
        .write_initial_command_word_2_4 (write_initial_command_word_2_4),
        .write_operation_control_word_1 (write_operation_control_word_1),
        .write_operation_control_word_2 (write_operation_control_word_2),
        .write_operation_control_word_3 (write_operation_control_word_3),
        .init_pulse                     (init_pulse),
        .init_done                      (init_done),
        .ltim                           (ltim),
        .adi                            (adi),
        .single_mode                    (single_mode),
        .icw1_addr                      (icw1_addr),
        .vector_address                 (vector_address),
        .cascade_config                 (cascade_config),
        .sfnm                           (sfnm),
        .buf_mode                       (buf_mode),
        .master_slave                   (master_slave),
        .aeoi                           (aeoi),
        .upm                            (upm),
        .imr                            (imr),
        .seq_error                      (seq_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    // Drive one strobe for a single cycle; returns at the next negedge with registers updated.
    task automatic pulse(input int which, input logic [7:0] data);
        @(negedge clock);
        internal_data_bus = data;
        case (which)
            1: write_initial_command_word_1   = 1'b1;
            2: write_initial_command_word_2_4 = 1'b1;
            3: write_operation_control_word_1 = 1'b1;
            4: write_operation_control_word_2 = 1'b1;
            5: write_operation_control_word_3 = 1'b1;
            default: ;
        endcase
        @(negedge clock);
        write_initial_command_word_1   = 1'b0;
        write_initial_command_word_2_4 = 1'b0;
        write_operation_control_word_1 = 1'b0;
        write_operation_control_word_2 = 1'b0;
        write_operation_control_word_3 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        internal_data_bus = 8'h00;
        write_initial_command_word_1   = 1'b0;
        write_initial_command_word_2_4 = 1'b0;
        write_operation_control_word_1 = 1'b0;
        write_operation_control_word_2 = 1'b0;
        write_operation_control_word_3 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        check("rst_imr", imr, 8'hFF);
        check("rst_init_done", {7'd0, init_done}, 8'h00);
        check("rst_vector", vector_address, 8'h00);
        check("rst_seq_error", {7'd0, seq_error}, 8'h00);

        // A0 write in IDLE is ignored
        pulse(2, 8'h77);
        check("idle_a0_imr", imr, 8'hFF);
        check("idle_a0_vector", vector_address, 8'h00);

        // Test 1: single, IC4 -> WAIT_ICW3 skipped
        pulse(1, 8'h13);
        check("t1_init_pulse", {7'd0, init_pulse}, 8'h01);
        check("t1_imr_init", imr, 8'h00);
        check("t1_single", {7'd0, single_mode}, 8'h01);
        pulse(2, 8'h48);
        check("t1_vector", vector_address, 8'h48);
        check("t1_state_icw4", {5'd0, dut.state}, {5'd0, WAIT_ICW4});
        check("t1_not_done", {7'd0, init_done}, 8'h00);
        pulse(2, 8'h03);
        check("t1_done", {7'd0, init_done}, 8'h01);
        check("t1_icw4", {3'd0, sfnm, buf_mode, master_slave, aeoi, upm}, 8'h03);
        check("t1_cascade", cascade_config, 8'h00);

        // Test 2: cascade with IC4, using the OCW1-aliased strobe for ICW3
        pulse(1, 8'h11);
        pulse(2, 8'h20);
        check("t2_vector", vector_address, 8'h20);
        check("t2_state_icw3", {5'd0, dut.state}, {5'd0, WAIT_ICW3});
        pulse(3, 8'h04);
        check("t2_cascade", cascade_config, 8'h04);
        pulse(2, 8'h1D);
        check("t2_icw4", {3'd0, sfnm, buf_mode, master_slave, aeoi, upm}, 8'h1D);
        check("t2_done", {7'd0, init_done}, 8'h01);

        // Test 3: LTIM, single, no IC4; ICW1 clears ICW4 fields and cascade
        pulse(1, 8'h1A);
        check("t3_icw4_cleared", {3'd0, sfnm, buf_mode, master_slave, aeoi, upm}, 8'h00);
        check("t3_cascade_cleared", cascade_config, 8'h00);
        check("t3_ltim", {7'd0, ltim}, 8'h01);
        pulse(2, 8'h08);
        check("t3_done", {7'd0, init_done}, 8'h01);
        check("t3_vector", vector_address, 8'h08);

        // Test 4: OCW1 in READY, then re-init
        pulse(3, 8'hA5);
        check("t4_imr", imr, 8'hA5);
        check("t4_still_ready", {7'd0, init_done}, 8'h01);
        pulse(2, 8'h3C);
        check("t4_imr_alias", imr, 8'h3C);
        pulse(1, 8'h13);
        check("t4_imr_reinit", imr, 8'h00);
        check("t4_done_fell", {7'd0, init_done}, 8'h00);
        check("t4_pulse_hi", {7'd0, init_pulse}, 8'h01);
        @(negedge clock);
        check("t4_pulse_lo", {7'd0, init_pulse}, 8'h00);

        // Test 5: reset mid-sequence in WAIT_ICW3
        pulse(1, 8'h11);
        pulse(2, 8'h20);
        do_reset();
        check("t5_state", {5'd0, dut.state}, {5'd0, IDLE});
        check("t5_imr", imr, 8'hFF);
        check("t5_vector", vector_address, 8'h00);
        pulse(2, 8'h55);
        check("t5_ignored_imr", imr, 8'hFF);
        check("t5_ignored_cascade", cascade_config, 8'h00);

        // ICW1 colliding with an A0 write: ICW1 wins, A0 data dropped
        @(negedge clock);
        internal_data_bus = 8'hB7;
        write_initial_command_word_1   = 1'b1;
        write_initial_command_word_2_4 = 1'b1;
        @(negedge clock);
        write_initial_command_word_1   = 1'b0;
        write_initial_command_word_2_4 = 1'b0;
        check("col_state", {5'd0, dut.state}, {5'd0, WAIT_ICW2});
        check("col_vector", vector_address, 8'h00);
        check("col_addr", {5'd0, icw1_addr}, 8'h05);
        check("col_adi", {7'd0, adi}, 8'h01);

        // OCW2/OCW3 never change registers
        pulse(4, 8'hEE);
        pulse(5, 8'hEE);
        check("ocw23_vector", vector_address, 8'h00);
        check("ocw23_state", {5'd0, dut.state}, {5'd0, WAIT_ICW2});

`ifdef ICW_SEQ_ERROR_EN
        // Test 6: OCW2 outside READY sets sticky seq_error; ICW1 clears it
        do_reset();
        pulse(1, 8'h13);
        check("t6_clear", {7'd0, seq_error}, 8'h00);
        pulse(4, 8'h00);
        check("t6_set", {7'd0, seq_error}, 8'h01);
        pulse(2, 8'h48);
        pulse(2, 8'h03);
        check("t6_ready", {7'd0, init_done}, 8'h01);
        check("t6_hold", {7'd0, seq_error}, 8'h01);
        pulse(1, 8'h13);
        check("t6_cleared", {7'd0, seq_error}, 8'h00);
`else
        check("no_checker_seq_error", {7'd0, seq_error}, 8'h00);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
